// File: rtl/mem_port_arbiter.sv
// Arbitrates the single memory_pdp port between fetch reads, exec reads and exec writes.
// One transaction in flight at a time; fixed priority with a fetch anti-starvation override.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 12
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 12
`endif

module mem_port_arbiter #(
   parameter int RD_LATENCY = 1,
   parameter int MAX_WAIT   = 4
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   ifu_rd_req,
   input  logic [`ADDR_WIDTH-1:0] ifu_rd_addr,
   output logic [`DATA_WIDTH-1:0] ifu_rd_data,
   output logic                   ifu_rd_valid,
   input  logic                   exec_rd_req,
   input  logic [`ADDR_WIDTH-1:0] exec_rd_addr,
   output logic [`DATA_WIDTH-1:0] exec_rd_data,
   output logic                   exec_rd_valid,
   input  logic                   exec_wr_req,
   input  logic [`ADDR_WIDTH-1:0] exec_wr_addr,
   input  logic [`DATA_WIDTH-1:0] exec_wr_data,
   output logic                   exec_wr_ack,
   output logic                   mem_rd_req,
   output logic [`ADDR_WIDTH-1:0] mem_rd_addr,
   input  logic [`DATA_WIDTH-1:0] mem_rd_data,
   output logic                   mem_wr_req,
   output logic [`ADDR_WIDTH-1:0] mem_wr_addr,
   output logic [`DATA_WIDTH-1:0] mem_wr_data,
   output logic                   arb_busy
);

   localparam logic [3:0] LAT  = 4'(RD_LATENCY);
   localparam logic [3:0] MAXW = 4'(MAX_WAIT);

   typedef enum logic [2:0] {IDLE, RD_ISSUE, RD_WAIT, RETURN, WR} state_t;

   state_t     state_q, state_d;
   logic       own_ifu_q, own_ifu_d;
   logic [3:0] lat_cnt_q, lat_cnt_d;
   logic [3:0] starve_cnt_q, starve_cnt_d;
   logic       grant_ifu, grant_exec_rd, grant_wr, capture;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= IDLE;
         own_ifu_q    <= 1'b0;
         lat_cnt_q    <= '0;
         starve_cnt_q <= '0;
      end else begin
         state_q      <= state_d;
         own_ifu_q    <= own_ifu_d;
         lat_cnt_q    <= lat_cnt_d;
         starve_cnt_q <= starve_cnt_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      own_ifu_d     = own_ifu_q;
      lat_cnt_d     = lat_cnt_q;
      grant_ifu     = 1'b0;
      grant_exec_rd = 1'b0;
      grant_wr      = 1'b0;
      capture       = 1'b0;
      case (state_q)
         IDLE: begin
            lat_cnt_d = '0;
            // a starved fetch outranks everything, including a pending write
            if (ifu_rd_req && starve_cnt_q == MAXW) grant_ifu = 1'b1;
            else if (exec_wr_req)                   grant_wr = 1'b1;
            else if (exec_rd_req)                   grant_exec_rd = 1'b1;
            else if (ifu_rd_req)                    grant_ifu = 1'b1;
            if (grant_wr) begin
               state_d = WR;
            end else if (grant_ifu || grant_exec_rd) begin
               state_d   = RD_ISSUE;
               own_ifu_d = grant_ifu;
               lat_cnt_d = 4'd1;
            end
         end
         RD_ISSUE: state_d = RD_WAIT;
         RD_WAIT: begin
            if (lat_cnt_q == LAT) begin
               capture = 1'b1;
               state_d = RETURN;
            end else begin
               lat_cnt_d = lat_cnt_q + 4'd1;
            end
         end
         RETURN: begin
            state_d   = IDLE;
            lat_cnt_d = '0;
         end
         WR:      state_d = IDLE;
         default: state_d = IDLE;
      endcase

      // starvation is tracked in every cycle, busy or idle
      if (!ifu_rd_req || grant_ifu) starve_cnt_d = '0;
      else if (starve_cnt_q < MAXW)  starve_cnt_d = starve_cnt_q + 4'd1;
      else                           starve_cnt_d = starve_cnt_q;
   end

   // All outputs are flops keyed off the next state so strobes line up with the state they belong to.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ifu_rd_data   <= '0;
         ifu_rd_valid  <= 1'b0;
         exec_rd_data  <= '0;
         exec_rd_valid <= 1'b0;
         exec_wr_ack   <= 1'b0;
         mem_rd_req    <= 1'b0;
         mem_rd_addr   <= '0;
         mem_wr_req    <= 1'b0;
         mem_wr_addr   <= '0;
         mem_wr_data   <= '0;
         arb_busy      <= 1'b0;
      end else begin
         mem_rd_req    <= (state_d == RD_ISSUE);
         mem_wr_req    <= (state_d == WR);
         exec_wr_ack   <= (state_d == WR);
         ifu_rd_valid  <= (state_d == RETURN) &&  own_ifu_q;
         exec_rd_valid <= (state_d == RETURN) && !own_ifu_q;
         arb_busy      <= (state_d != IDLE);
         if (grant_ifu)          mem_rd_addr <= ifu_rd_addr;
         else if (grant_exec_rd) mem_rd_addr <= exec_rd_addr;
         if (grant_wr) begin
            mem_wr_addr <= exec_wr_addr;
            mem_wr_data <= exec_wr_data;
         end
         if (capture) begin
            if (own_ifu_q) ifu_rd_data  <= mem_rd_data;
            else           exec_rd_data <= mem_rd_data;
         end
      end
   end

endmodule
